// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the fetch address and loads the IF/ID register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instructionAddress,
  input  logic [31:0] instruction,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count,
`endif
  output logic        if_id_valid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pcp4_q, ifid_pcp4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        load_fetch, load_bubble;
  logic [31:0] pc_plus4;

  // Wraps modulo 2^32 by construction.
  assign pc_plus4 = pc_q + 32'd4;

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pcp4_d  = ifid_pcp4_q;
    ifid_valid_d = ifid_valid_q;
    load_fetch   = 1'b0;
    load_bubble  = 1'b0;
    if (branch_taken) begin
      pc_d        = {branch_target[31:2], 2'b00};
      load_bubble = 1'b1;
    end else if (stall) begin
      load_bubble = flush;
    end else begin
      if (flush || !imem_ready) load_bubble = 1'b1;
      else                      load_fetch  = 1'b1;
      // A flush squashes the decoded slot only; sequential fetch continues.
      if (imem_ready) pc_d = pc_plus4;
    end

    if (load_bubble) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pcp4_d  = 32'h0;
      ifid_valid_d = 1'b0;
    end else if (load_fetch) begin
      ifid_instr_d = instruction;
      ifid_pcp4_d  = pc_plus4;
      ifid_valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pcp4_q  <= 32'h0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pcp4_q  <= ifid_pcp4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign instructionAddress = pc_q;
  assign if_id_instruction  = ifid_instr_q;
  assign if_id_pc_plus4     = ifid_pcp4_q;
  assign if_id_valid        = ifid_valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  // Stall-hold cycles load neither, so they count in neither.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      if (load_fetch)  fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (load_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule
